// File: rtl/branch_resolve_if.sv
// Control-FSM to branch-resolve handshake: request fields in, PC/link/status/stats out.
interface branch_resolve_if #(parameter int CNT_W = 32);
    logic             start;
    logic [1:0]       kind;
    logic             br_en;
    logic [31:0]      imm;
    logic [31:0]      rs1;
    logic [31:0]      pc_out;
    logic [31:0]      link;
    logic             done;
    logic             taken;
    logic             misalign;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output start, kind, br_en, imm, rs1,
        input  pc_out, link, done, taken, misalign, branch_count, taken_count
    );

    modport slave (
        input  start, kind, br_en, imm, rs1,
        output pc_out, link, done, taken, misalign, branch_count, taken_count
    );
endinterface

// File: rtl/branch_resolve.sv
// Architectural PC owner for the multicycle RV32I core: resolves branch/JAL/JALR/
// sequential flow in a fixed IDLE->CALC->DONE sequence and keeps branch statistics.
module branch_resolve #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060,
    parameter int          CNT_W    = 32
) (
    input logic             clk,
    input logic             rst,
    branch_resolve_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, link_q, imm_q, rs1_q;
    logic [1:0]       kind_q;
    logic             taken_q, misalign_q, done_c;
    logic [CNT_W-1:0] branch_cnt_q, taken_cnt_q;

    logic [31:0] pc_plus4, target, next_pc;
    logic        taken_c, misalign_c;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done_c  = 1'b0;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    state_d = DONE;
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Target selection works off the operands latched at start, so the
    // requester may change kind/imm/rs1 freely once start is accepted.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        case (kind_q)
            2'b00, 2'b01: target = pc_q + imm_q;
            2'b10:        target = (rs1_q + imm_q) & ~32'd1;
            default:      target = pc_plus4;
        endcase
        taken_c    = (kind_q == 2'b01) || (kind_q == 2'b10) ||
                     ((kind_q == 2'b00) && bus.br_en);
        next_pc    = taken_c ? target : pc_plus4;
        misalign_c = taken_c && (next_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            link_q       <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            kind_q       <= 2'b11;
            taken_q      <= 1'b0;
            misalign_q   <= 1'b0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            if (state_q == IDLE && bus.start) begin
                kind_q <= bus.kind;
                imm_q  <= bus.imm;
                rs1_q  <= bus.rs1;
                link_q <= pc_q + 32'd4;
            end
            if (state_q == CALC) begin
                // A misaligned target is reported but never committed.
                if (!misalign_c) pc_q <= next_pc;
                taken_q    <= taken_c;
                misalign_q <= misalign_c;
                if (kind_q == 2'b00) begin
                    if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
                    if (bus.br_en && taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.link         = link_q;
    assign bus.done         = done_c;
    assign bus.taken        = taken_q;
    assign bus.misalign     = misalign_q;
    assign bus.branch_count = branch_cnt_q;
    assign bus.taken_count  = taken_cnt_q;
endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve; counters are narrowed to 3 bits so saturation is reachable.
module tb_branch_resolve;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   errors  = 0;
    int   dones;

    always #5 clk = ~clk;

    branch_resolve_if #(.CNT_W(CW)) bus ();
    branch_resolve #(.RESET_PC(32'h0000_0060), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one resolution; returns in the DONE cycle, 1 time unit after the edge.
    task automatic resolve(input logic [1:0] k, input logic [31:0] im, input logic [31:0] r1,
                           input logic be);
        bus.start = 1'b1; bus.kind = k; bus.imm = im; bus.rs1 = r1; bus.br_en = be;
        tick();
        bus.start = 1'b0;
        chk("calc_done_low", {31'd0, bus.done}, 32'd0);
        tick();
        chk("done_pulse", {31'd0, bus.done}, 32'd1);
    endtask

    task automatic finish_done();
        tick();
        chk("done_cleared", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.kind = 2'b11; bus.imm = '0; bus.rs1 = '0; bus.br_en = 1'b0;

        // Reset
        rst = 1'b0; tick(); tick();
        chk("rst_pc", bus.pc_out, 32'h60);
        chk("rst_link", bus.link, 32'h0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_taken", {31'd0, bus.taken}, 32'd0);
        chk("rst_mis", {31'd0, bus.misalign}, 32'd0);
        chk("rst_bcnt", 32'(bus.branch_count), 32'd0);
        rst = 1'b1;

        // Sequential
        resolve(2'b11, 32'h0, 32'h0, 1'b1);
        chk("seq_pc", bus.pc_out, 32'h64);
        chk("seq_link", bus.link, 32'h64);
        chk("seq_taken", {31'd0, bus.taken}, 32'd0);
        finish_done();

        // Back to 0x60 for the taken branch
        rst = 1'b0; tick(); rst = 1'b1;
        resolve(2'b00, 32'hFFFF_FFF0, 32'h0, 1'b1);
        chk("tb_pc", bus.pc_out, 32'h50);
        chk("tb_taken", {31'd0, bus.taken}, 32'd1);
        chk("tb_link", bus.link, 32'h64);
        chk("tb_bcnt", 32'(bus.branch_count), 32'd1);
        chk("tb_tcnt", 32'(bus.taken_count), 32'd1);
        finish_done();
        chk("hold_taken", {31'd0, bus.taken}, 32'd1);

        // Not-taken branch
        resolve(2'b00, 32'h100, 32'h0, 1'b0);
        chk("nt_pc", bus.pc_out, 32'h54);
        chk("nt_taken", {31'd0, bus.taken}, 32'd0);
        chk("nt_bcnt", 32'(bus.branch_count), 32'd2);
        chk("nt_tcnt", 32'(bus.taken_count), 32'd1);
        finish_done();

        // JALR misaligned, then aligned
        resolve(2'b10, 32'h2, 32'h1001, 1'b0);
        chk("jalr_mis", {31'd0, bus.misalign}, 32'd1);
        chk("jalr_mis_pc", bus.pc_out, 32'h54);
        chk("jalr_mis_link", bus.link, 32'h58);
        chk("jalr_mis_bcnt", 32'(bus.branch_count), 32'd2);
        finish_done();
        resolve(2'b10, 32'h3, 32'h1001, 1'b0);
        chk("jalr_pc", bus.pc_out, 32'h1004);
        chk("jalr_ok", {31'd0, bus.misalign}, 32'd0);
        chk("jalr_taken", {31'd0, bus.taken}, 32'd1);
        finish_done();

        // JAL ignores br_en
        resolve(2'b01, 32'h10, 32'h0, 1'b0);
        chk("jal_pc", bus.pc_out, 32'h1014);
        chk("jal_link", bus.link, 32'h1008);
        chk("jal_taken", {31'd0, bus.taken}, 32'd1);
        finish_done();

        // Misaligned taken branch: pc held, still counted
        resolve(2'b00, 32'h6, 32'h0, 1'b1);
        chk("bmis_pc", bus.pc_out, 32'h1014);
        chk("bmis_mis", {31'd0, bus.misalign}, 32'd1);
        chk("bmis_bcnt", 32'(bus.branch_count), 32'd3);
        chk("bmis_tcnt", 32'(bus.taken_count), 32'd2);
        finish_done();
        chk("hold_mis", {31'd0, bus.misalign}, 32'd1);

        // start pulses during CALC and DONE are ignored
        bus.start = 1'b1; bus.kind = 2'b11;
        tick();                         // CALC, start still high
        tick();                         // DONE, start still high
        chk("hs_done", {31'd0, bus.done}, 32'd1);
        tick();                         // IDLE
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done) dones++;
        end
        chk("hs_no_extra", 32'(dones), 32'd0);
        chk("hs_pc", bus.pc_out, 32'h1018);

        // start held continuously: one resolution every 3 cycles
        bus.start = 1'b1; bus.kind = 2'b11;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done) dones++;
        end
        bus.start = 1'b0;
        chk("held_dones", 32'(dones), 32'd2);
        chk("held_pc", bus.pc_out, 32'h1020);

        // Reset during CALC abandons the resolution
        bus.start = 1'b1; bus.kind = 2'b00; bus.imm = 32'h40; bus.br_en = 1'b1;
        tick();
        bus.start = 1'b0;
        rst = 1'b0;
        tick();
        chk("mrst_done", {31'd0, bus.done}, 32'd0);
        chk("mrst_pc", bus.pc_out, 32'h60);
        chk("mrst_bcnt", 32'(bus.branch_count), 32'd0);
        chk("mrst_tcnt", 32'(bus.taken_count), 32'd0);
        rst = 1'b1;
        tick();
        chk("mrst_done2", {31'd0, bus.done}, 32'd0);

        // Saturation: 8 taken branches into a 3-bit counter
        for (int i = 0; i < 7; i++) begin
            resolve(2'b00, 32'h0, 32'h0, 1'b1);
            tick();
        end
        chk("sat_bcnt7", 32'(bus.branch_count), 32'd7);
        resolve(2'b00, 32'h0, 32'h0, 1'b1);
        chk("sat_bcnt", 32'(bus.branch_count), 32'd7);
        chk("sat_tcnt", 32'(bus.taken_count), 32'd7);
        chk("sat_pc", bus.pc_out, 32'h60);
        finish_done();

        // PC wrap-around
        resolve(2'b10, 32'hC, 32'hFFFF_FFF0, 1'b0);
        chk("wrap_pre", bus.pc_out, 32'hFFFF_FFFC);
        finish_done();
        resolve(2'b11, 32'h0, 32'h0, 1'b1);
        chk("wrap_pc", bus.pc_out, 32'h0);
        chk("wrap_link", bus.link, 32'h0);
        chk("wrap_taken", {31'd0, bus.taken}, 32'd0);
        chk("wrap_mis", {31'd0, bus.misalign}, 32'd0);
        finish_done();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
